// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised multicycle accumulator-style CPU core.
// Fuses PC, control FSM, register file, ALU and a unified program/data RAM.
// Each instruction is three words (opcode, OP1, OP2) and takes four cycles
// (FETCH_OP, FETCH_1, FETCH_2, EXEC). A byte-stream load port fills RAM while
// the core is parked; a run strobe starts execution from address 0.
// Optional feature macro: CPU_RETIRE_CNT_EN adds a saturating 32-bit
// retired-instruction counter on output port 'retired'.
module cpu_core_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              run,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [3:0]        flags,
  output logic              busy,
  output logic              halted
`ifdef CPU_RETIRE_CNT_EN
  ,
  output logic [31:0]       retired
`endif
);

  localparam int unsigned RIW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned XW    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned MSB   = DATA_W - 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH_OP = 3'd1;
  localparam logic [2:0] S_FETCH_1  = 3'd2;
  localparam logic [2:0] S_FETCH_2  = 3'd3;
  localparam logic [2:0] S_EXEC     = 3'd4;
  localparam logic [2:0] S_HALT     = 3'd5;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Architectural and control state
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        ir_q, ir_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [3:0]        flags_q, flags_d;
  logic [ADDR_W-1:0] lptr_q, lptr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  // Memory write port, shared by the load port and ST
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Operand decode: register indices and zero-extended addresses
  logic [XW-1:0]       op1_x, op2_x;
  logic [ADDR_W-1:0]   op1_addr, op2_addr;
  logic [RIW-1:0]      rd_idx, rs_idx;
  logic [DATA_W-1:0]   rd_val, rs_val;
  logic                unused_bits;

  assign op1_x       = XW'(op1_q);
  assign op2_x       = XW'(op2_q);
  assign op1_addr    = op1_x[ADDR_W-1:0];
  assign op2_addr    = op2_x[ADDR_W-1:0];
  assign rd_idx      = op1_q[RIW-1:0];
  assign rs_idx      = op2_q[RIW-1:0];
  assign rd_val      = regs_q[rd_idx];
  assign rs_val      = regs_q[rs_idx];
  assign unused_bits = ^{op1_x, op2_x};

  // ALU datapath
  logic [DATA_W:0]   sum_w, dif_w;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v, alu_op;

  // Compute ALU result and carry/overflow for the current opcode
  always_comb begin
    sum_w   = {1'b0, rd_val} + {1'b0, rs_val};
    dif_w   = {1'b0, rd_val} - {1'b0, rs_val};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_op  = 1'b1;
    case (ir_q)
      OP_ADD: begin
        alu_res = sum_w[DATA_W-1:0];
        alu_c   = sum_w[DATA_W];
        alu_v   = (rd_val[MSB] == rs_val[MSB]) && (alu_res[MSB] != rd_val[MSB]);
      end
      OP_SUB: begin
        alu_res = dif_w[DATA_W-1:0];
        alu_c   = dif_w[DATA_W];
        alu_v   = (rd_val[MSB] != rs_val[MSB]) && (alu_res[MSB] != rd_val[MSB]);
      end
      OP_AND:  alu_res = rd_val & rs_val;
      OP_OR:   alu_res = rd_val | rs_val;
      OP_XOR:  alu_res = rd_val ^ rs_val;
      default: alu_op  = 1'b0;
    endcase
  end

  // Next-state logic: load mode overrides the FSM, otherwise step the FSM
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    regs_d    = regs_q;
    alu_d     = alu_q;
    flags_d   = flags_q;
    lptr_d    = '0;
    mem_we    = 1'b0;
    mem_waddr = lptr_q;
    mem_wdata = prog_data;
    if (prog_mode) begin
      // Forcing IDLE here also drops any pending EXEC writeback or ST
      state_d = S_IDLE;
      lptr_d  = lptr_q;
      if (prog_we) begin
        mem_we = 1'b1;
        lptr_d = lptr_q + ADDR_W'(1);
      end
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (run) begin
            pc_d    = '0;
            state_d = S_FETCH_OP;
          end
        end
        S_FETCH_OP: begin
          ir_d    = mem[pc_q][3:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FETCH_1;
        end
        S_FETCH_1: begin
          op1_d   = mem[pc_q];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FETCH_2;
        end
        S_FETCH_2: begin
          op2_d   = mem[pc_q];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_EXEC;
        end
        S_EXEC: begin
          state_d = S_FETCH_OP;
          if (alu_op) begin
            regs_d[rd_idx] = alu_res;
            alu_d          = alu_res;
            flags_d        = {alu_v, alu_res[MSB], alu_c, (alu_res == '0)};
          end
          case (ir_q)
            OP_LDI: regs_d[rd_idx] = op2_q;
            OP_MOV: regs_d[rd_idx] = rs_val;
            OP_JMP: pc_d = op1_addr;
            OP_JZ:  if (flags_q[0]) pc_d = op1_addr;
            OP_LD:  regs_d[rd_idx] = mem[op2_addr];
            OP_ST: begin
              mem_we    = 1'b1;
              mem_waddr = op2_addr;
              mem_wdata = rd_val;
            end
            OP_HLT: state_d = S_HALT;
            default: ;
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      alu_q   <= '0;
      flags_q <= '0;
      lptr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      regs_q  <= regs_d;
      alu_q   <= alu_d;
      flags_q <= flags_d;
      lptr_q  <= lptr_d;
    end
  end

  // RAM write port; contents survive reset, but reset blocks a pending write
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef CPU_RETIRE_CNT_EN
  logic [31:0] ret_q;

  // Count completed EXEC cycles, saturating; cleared by reset and by run
  always_ff @(posedge clk) begin
    if (!rst) begin
      ret_q <= '0;
    end else if (!prog_mode) begin
      if (((state_q == S_IDLE) || (state_q == S_HALT)) && run) begin
        ret_q <= '0;
      end else if ((state_q == S_EXEC) && (ret_q != '1)) begin
        ret_q <= ret_q + 32'd1;
      end
    end
  end

  assign retired = ret_q;
`endif

  assign pc_out  = pc_q;
  assign alu_out = alu_q;
  assign flags   = flags_q;
  assign busy    = (state_q == S_FETCH_OP) || (state_q == S_FETCH_1) ||
                   (state_q == S_FETCH_2)  || (state_q == S_EXEC);
  assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_core_param.sv
// Self-checking bench for cpu_core_param: directed scenarios plus random
// whole-memory programs compared against an instruction-level ISA model.
module tb_cpu_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, prog_mode, prog_we, run;
  logic [7:0] prog_data;
  logic [7:0] pc_out, alu_out;
  logic [3:0] flags;
  logic       busy, halted;

  logic       w_prog_mode, w_prog_we, w_run;
  logic [7:0] w_prog_data;
  logic [3:0] w_pc_out;
  logic [7:0] w_alu_out;
  logic [3:0] w_flags;
  logic       w_busy, w_halted;

`ifdef CPU_RETIRE_CNT_EN
  logic [31:0] retired, w_retired;
`endif

  cpu_core_param #(.DATA_W(8), .ADDR_W(8), .NUM_REGS(4)) dut (
    .clk(clk), .rst(rst), .prog_mode(prog_mode), .prog_we(prog_we),
    .prog_data(prog_data), .run(run), .pc_out(pc_out), .alu_out(alu_out),
    .flags(flags), .busy(busy), .halted(halted)
`ifdef CPU_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  cpu_core_param #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(4)) wdut (
    .clk(clk), .rst(rst), .prog_mode(w_prog_mode), .prog_we(w_prog_we),
    .prog_data(w_prog_data), .run(w_run), .pc_out(w_pc_out), .alu_out(w_alu_out),
    .flags(w_flags), .busy(w_busy), .halted(w_halted)
`ifdef CPU_RETIRE_CNT_EN
    , .retired(w_retired)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  int img [256];

  // ISA-level reference model state
  int m_mem [256];
  int m_reg [4];
  int m_pc, m_alu, m_flags, m_halt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_main(input int n);
    prog_mode = 1'b1;
    for (int i = 0; i < n; i++) begin
      prog_we   = 1'b1;
      prog_data = 8'(img[i]);
      tick();
    end
    prog_we   = 1'b0;
    prog_mode = 1'b0;
    tick();
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_pc = 0; m_alu = 0; m_flags = 0; m_halt = 0;
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Execute one whole instruction at ISA level
  task automatic model_step();
    int op, a1, a2, rd, rs, x, y, r, res, c, v;
    if (m_halt != 0) return;
    op = m_mem[m_pc];
    a1 = m_mem[(m_pc + 1) % 256];
    a2 = m_mem[(m_pc + 2) % 256];
    m_pc = (m_pc + 3) % 256;
    rd = a1 % 4; rs = a2 % 4;
    x = m_reg[rd]; y = m_reg[rs];
    r = -1; c = 0; v = 0;
    case (op % 16)
      1:  m_reg[rd] = a2;
      2:  begin r = x + y; c = (r > 255); v = (sgn(x) + sgn(y) > 127) || (sgn(x) + sgn(y) < -128); end
      3:  begin r = x - y; c = (x < y);   v = (sgn(x) - sgn(y) > 127) || (sgn(x) - sgn(y) < -128); end
      4:  r = x & y;
      5:  r = x | y;
      6:  r = x ^ y;
      7:  m_reg[rd] = y;
      8:  m_pc = a1;
      9:  if ((m_flags % 2) == 1) m_pc = a1;
      10: m_reg[rd] = m_mem[a2];
      11: m_mem[a2] = x;
      15: m_halt = 1;
      default: ;
    endcase
    if (r != -1) begin
      res = r & 255;
      m_reg[rd] = res;
      m_alu = res;
      m_flags = v * 8 + ((res >= 128) ? 4 : 0) + c * 2 + ((res == 0) ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_checks += 5;
    if (pc_out !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", pc_out); end
    if (alu_out !== 8'h00) begin n_fail++; $display("FAIL reset_alu: got %h want 00", alu_out); end
    if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_checks += 2;
    if (w_pc_out !== 4'h0) begin n_fail++; $display("FAIL reset_wpc: got %h want 0", w_pc_out); end
    if (w_busy !== 1'b0) begin n_fail++; $display("FAIL reset_wbusy: got %b want 0", w_busy); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_run();
    int p [12] = '{8'h01,8'h00,8'h05, 8'h01,8'h01,8'h03, 8'h02,8'h00,8'h01, 8'h0F,8'h00,8'h00};
    for (int i = 0; i < 12; i++) img[i] = p[i];
    load_main(12);
    pulse_run();
    repeat (15) tick();
    n_checks += 2;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL lr_early_halt: got %b want 0", halted); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL lr_busy: got %b want 1", busy); end
    tick();
    n_checks += 4;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL lr_halted: got %b want 1", halted); end
    if (alu_out !== 8'h08) begin n_fail++; $display("FAIL lr_alu: got %h want 08", alu_out); end
    if (flags !== 4'b0000) begin n_fail++; $display("FAIL lr_flags: got %b want 0000", flags); end
    if (pc_out !== 8'h0C) begin n_fail++; $display("FAIL lr_pc: got %h want 0c", pc_out); end
`ifdef CPU_RETIRE_CNT_EN
    n_checks++;
    if (retired !== 32'd4) begin n_fail++; $display("FAIL lr_retired: got %0d want 4", retired); end
`endif
  endtask

  task automatic test_sub_branch();
    int p [19] = '{8'h01,8'h00,8'h03, 8'h01,8'h01,8'h03, 8'h03,8'h00,8'h01, 8'h09,8'h10,8'h00,
                   8'h0F,8'h00,8'h00, 8'h00, 8'h0F,8'h00,8'h00};
    for (int i = 0; i < 19; i++) img[i] = p[i];
    load_main(19);
    pulse_run();
    repeat (16) tick();
    n_checks += 3;
    if (pc_out !== 8'h10) begin n_fail++; $display("FAIL jz_target: got %h want 10", pc_out); end
    if (flags !== 4'b0001) begin n_fail++; $display("FAIL sub_flags: got %b want 0001", flags); end
    if (halted !== 1'b0) begin n_fail++; $display("FAIL jz_skip: got halted %b want 0", halted); end
    repeat (4) tick();
    n_checks += 2;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL jz_halt: got %b want 1", halted); end
    if (pc_out !== 8'h13) begin n_fail++; $display("FAIL jz_pc: got %h want 13", pc_out); end
  endtask

  task automatic test_overflow();
    int p [21] = '{8'h01,8'h00,8'h7F, 8'h01,8'h01,8'h01, 8'h02,8'h00,8'h01,
                   8'h01,8'h02,8'hFF, 8'h01,8'h03,8'h01, 8'h02,8'h02,8'h03, 8'h0F,8'h00,8'h00};
    for (int i = 0; i < 21; i++) img[i] = p[i];
    load_main(21);
    pulse_run();
    repeat (12) tick();
    n_checks += 2;
    if (alu_out !== 8'h80) begin n_fail++; $display("FAIL ovf_alu: got %h want 80", alu_out); end
    if (flags !== 4'b1100) begin n_fail++; $display("FAIL ovf_flags: got %b want 1100", flags); end
    repeat (12) tick();
    n_checks += 2;
    if (alu_out !== 8'h00) begin n_fail++; $display("FAIL carry_alu: got %h want 00", alu_out); end
    if (flags !== 4'b0011) begin n_fail++; $display("FAIL carry_flags: got %b want 0011", flags); end
  endtask

  task automatic test_abort();
    int p2 [12] = '{8'h0A,8'h02,8'h20, 8'h01,8'h03,8'h00, 8'h05,8'h02,8'h03, 8'h0F,8'h00,8'h00};
    for (int i = 0; i < 33; i++) img[i] = 0;
    img[0] = 8'h01; img[1] = 8'h01; img[2] = 8'h5A;
    img[3] = 8'h0B; img[4] = 8'h01; img[5] = 8'h20;
    img[6] = 8'h0F;
    img[32] = 8'h33;
    load_main(33);
    pulse_run();
    repeat (6) tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
    prog_mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      prog_we   = 1'b1;
      prog_data = 8'(p2[i]);
      tick();
      if (i == 0) begin
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_busy: got %b want 0", busy); end
        if (halted !== 1'b0) begin n_fail++; $display("FAIL abort_idle_halt: got %b want 0", halted); end
      end
    end
    prog_we = 1'b0;
    prog_mode = 1'b0;
    tick();
    pulse_run();
    repeat (16) tick();
    n_checks += 3;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL abort_rerun_halt: got %b want 1", halted); end
    if (alu_out !== 8'h33) begin n_fail++; $display("FAIL abort_mem20: got %h want 33", alu_out); end
    if (flags !== 4'b0000) begin n_fail++; $display("FAIL abort_flags: got %b want 0000", flags); end
  endtask

  task automatic test_wrap();
    int p [16] = '{8'hC0,8'h00,8'h00, 8'h01,8'h01,8'h01, 8'h02,8'h00,8'h01,
                   8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00, 8'h08};
    w_prog_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w_prog_we   = 1'b1;
      w_prog_data = 8'(p[i]);
      tick();
    end
    w_prog_we = 1'b0;
    w_prog_mode = 1'b0;
    tick();
    w_run = 1'b1;
    tick();
    w_run = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (w_pc_out !== 4'hF) begin n_fail++; $display("FAIL wrap_pc15: got %h want f", w_pc_out); end
    tick();
    n_checks++;
    if (w_pc_out !== 4'h0) begin n_fail++; $display("FAIL wrap_fetch: got %h want 0", w_pc_out); end
    repeat (3) tick();
    n_checks += 2;
    if (w_pc_out !== 4'h0) begin n_fail++; $display("FAIL wrap_jmp: got %h want 0", w_pc_out); end
    if (w_alu_out !== 8'h01) begin n_fail++; $display("FAIL wrap_loop1: got %h want 01", w_alu_out); end
    repeat (48) tick();
    n_checks += 4;
    if (w_pc_out !== 4'h0) begin n_fail++; $display("FAIL wrap_pc3: got %h want 0", w_pc_out); end
    if (w_alu_out !== 8'h03) begin n_fail++; $display("FAIL wrap_loop3: got %h want 03", w_alu_out); end
    if (w_flags !== 4'b0000) begin n_fail++; $display("FAIL wrap_flags: got %b want 0000", w_flags); end
    if (w_busy !== 1'b1) begin n_fail++; $display("FAIL wrap_busy: got %b want 1", w_busy); end
  endtask

  task automatic test_random(input int trials);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    for (int t = 0; t < trials; t++) begin
      for (int i = 0; i < 256; i++) begin
        img[i] = int'($urandom_range(255, 0));
        m_mem[i] = img[i];
      end
      load_main(256);
      m_pc = 0;
      m_halt = 0;
      pulse_run();
      for (int k = 0; k < 40; k++) begin
        model_step();
        repeat (4) tick();
        n_checks += 4;
        if (pc_out !== 8'(m_pc)) begin n_fail++; $display("FAIL rnd_pc t%0d k%0d: got %h want %h", t, k, pc_out, 8'(m_pc)); end
        if (alu_out !== 8'(m_alu)) begin n_fail++; $display("FAIL rnd_alu t%0d k%0d: got %h want %h", t, k, alu_out, 8'(m_alu)); end
        if (flags !== 4'(m_flags)) begin n_fail++; $display("FAIL rnd_flags t%0d k%0d: got %b want %b", t, k, flags, 4'(m_flags)); end
        if (halted !== 1'(m_halt)) begin n_fail++; $display("FAIL rnd_halt t%0d k%0d: got %b want %b", t, k, halted, 1'(m_halt)); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; prog_mode = 1'b0; prog_we = 1'b0; prog_data = '0; run = 1'b0;
    w_prog_mode = 1'b0; w_prog_we = 1'b0; w_prog_data = '0; w_run = 1'b0;
    test_reset();
    test_load_run();
    test_sub_branch();
    test_overflow();
    test_abort();
    test_wrap();
    test_random(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
